// File: rtl/car_alarm_pkg.sv
// -----------------------------------------------------------------------------
// car_alarm_pkg
// Shared definitions for the car-alarm sequencing controller:
//   - STATE_W and the state encoding (DISARMED=0 .. ALARM=4; codes 5-7 illegal)
//   - default delay values used as parameter defaults by the top level
// -----------------------------------------------------------------------------
package car_alarm_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_DISARMED = 3'd0,
        ST_ARMING   = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_ALARM    = 3'd4
    } alarm_state_e;

    localparam int DEF_ARM_DELAY    = 6;
    localparam int DEF_ENTRY_DELAY  = 4;
    localparam int DEF_ALARM_CYCLES = 8;
    localparam int DEF_CNT_W        = 4;

endpackage

// File: rtl/alarm_timer.sv
// -----------------------------------------------------------------------------
// alarm_timer
// Shared down-counter for the ARMING, ENTRY and ALARM phases.
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous active-high reset (count cleared to 0)
//   load     - load load_val this cycle (takes precedence over dec)
//   load_val - value to load (delay minus one)
//   dec      - decrement by one; saturates at zero
//   zero     - registered flag, high while the count is zero
// -----------------------------------------------------------------------------
module alarm_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;

    // Next count: load wins over decrement; decrement never wraps below zero.
    always_comb begin
        cnt_next_s = cnt_r;
        if (load) begin
            cnt_next_s = load_val;
        end else if (dec && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_next_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Count register with the zero flag registered alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
            zero  <= 1'b1;
        end else begin
            cnt_r <= cnt_next_s;
            zero  <= (cnt_next_s == {CNT_W{1'b0}});
        end
    end

endmodule

// File: rtl/car_alarm_controller.sv
// -----------------------------------------------------------------------------
// car_alarm_controller
// Arm / entry-delay / alarm sequencer for the passive car-alarm datapath.
// Ports:
//   clk              - clock, rising edge
//   reset            - synchronous active-high reset
//   IgnitionSignalOn - ignition key on
//   OpenDoorSign     - any door open
//   CarLightsOnSign  - headlights on
//   DisarmKey        - key-fob disarm (pulse or level)
//   PassiveSignal_b  - buzzer (entry warning or lights-left-on chime), registered
//   PassiveSignal_s  - siren, registered
//   ArmedSign        - armed indicator, registered
//   AlarmState       - current state register (debug / monitor)
// Outputs are registered from the next state and the inputs sampled at the
// same edge, so every output is consistent with AlarmState.
// -----------------------------------------------------------------------------
module car_alarm_controller
    import car_alarm_pkg::*;
#(
    parameter int ARM_DELAY    = DEF_ARM_DELAY,
    parameter int ENTRY_DELAY  = DEF_ENTRY_DELAY,
    parameter int ALARM_CYCLES = DEF_ALARM_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               IgnitionSignalOn,
    input  logic               OpenDoorSign,
    input  logic               CarLightsOnSign,
    input  logic               DisarmKey,
    output logic               PassiveSignal_b,
    output logic               PassiveSignal_s,
    output logic               ArmedSign,
    output logic [STATE_W-1:0] AlarmState
);

    // Timer is loaded with delay-1 so that expiry (zero) lands exactly
    // DELAY edges after the state was entered.
    localparam logic [CNT_W-1:0] ARM_LOAD   = CNT_W'(ARM_DELAY - 1);
    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
    localparam logic [CNT_W-1:0] ALARM_LOAD = CNT_W'(ALARM_CYCLES - 1);

    alarm_state_e     state_r;
    alarm_state_e     next_state_s;
    logic             timer_load_s;
    logic [CNT_W-1:0] timer_load_val_s;
    logic             timer_dec_s;
    logic             timer_zero_s;
    logic             next_armed_s;
    logic             next_siren_s;
    logic             next_buzz_s;

    alarm_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load_s),
        .load_val (timer_load_val_s),
        .dec      (timer_dec_s),
        .zero     (timer_zero_s)
    );

    // Next-state and timer control; priority DisarmKey > ignition > door > expiry.
    always_comb begin
        next_state_s     = ST_DISARMED;
        timer_load_s     = 1'b0;
        timer_load_val_s = {CNT_W{1'b0}};
        timer_dec_s      = 1'b0;
        case (state_r)
            ST_DISARMED: begin
                // The fob has no effect here; only clean inputs start arming.
                if (!IgnitionSignalOn && !OpenDoorSign) begin
                    next_state_s     = ST_ARMING;
                    timer_load_s     = 1'b1;
                    timer_load_val_s = ARM_LOAD;
                end else begin
                    next_state_s = ST_DISARMED;
                end
            end
            ST_ARMING: begin
                if (DisarmKey || IgnitionSignalOn || OpenDoorSign) begin
                    next_state_s = ST_DISARMED;
                end else if (timer_zero_s) begin
                    next_state_s = ST_ARMED;
                end else begin
                    next_state_s = ST_ARMING;
                    timer_dec_s  = 1'b1;
                end
            end
            ST_ARMED: begin
                if (DisarmKey) begin
                    next_state_s = ST_DISARMED;
                end else if (IgnitionSignalOn) begin
                    // Ignition without a disarm is treated as a hotwire attempt.
                    next_state_s     = ST_ALARM;
                    timer_load_s     = 1'b1;
                    timer_load_val_s = ALARM_LOAD;
                end else if (OpenDoorSign) begin
                    next_state_s     = ST_ENTRY;
                    timer_load_s     = 1'b1;
                    timer_load_val_s = ENTRY_LOAD;
                end else begin
                    next_state_s = ST_ARMED;
                end
            end
            ST_ENTRY: begin
                // Closing the door does not cancel the grace period.
                if (DisarmKey) begin
                    next_state_s = ST_DISARMED;
                end else if (IgnitionSignalOn || timer_zero_s) begin
                    next_state_s     = ST_ALARM;
                    timer_load_s     = 1'b1;
                    timer_load_val_s = ALARM_LOAD;
                end else begin
                    next_state_s = ST_ENTRY;
                    timer_dec_s  = 1'b1;
                end
            end
            ST_ALARM: begin
                // Only the fob can cut the siren short.
                if (DisarmKey) begin
                    next_state_s = ST_DISARMED;
                end else if (timer_zero_s) begin
                    next_state_s = ST_ARMED;
                end else begin
                    next_state_s = ST_ALARM;
                    timer_dec_s  = 1'b1;
                end
            end
            default: begin
                next_state_s = ST_DISARMED;
            end
        endcase
    end

    // Output decode from the next state and the current inputs.
    always_comb begin
        next_armed_s = (next_state_s == ST_ARMED) || (next_state_s == ST_ENTRY) ||
                       (next_state_s == ST_ALARM);
        next_siren_s = (next_state_s == ST_ALARM);
        // Entry warning, or chime for headlights left on with a door open.
        next_buzz_s  = (next_state_s == ST_ENTRY) ||
                       (((next_state_s == ST_DISARMED) || (next_state_s == ST_ARMING)) &&
                        !IgnitionSignalOn && CarLightsOnSign && OpenDoorSign);
    end

    // State and output registers; reset clears everything on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= ST_DISARMED;
            ArmedSign       <= 1'b0;
            PassiveSignal_s <= 1'b0;
            PassiveSignal_b <= 1'b0;
        end else begin
            state_r         <= next_state_s;
            ArmedSign       <= next_armed_s;
            PassiveSignal_s <= next_siren_s;
            PassiveSignal_b <= next_buzz_s;
        end
    end

    assign AlarmState = state_r;

endmodule

// File: tb/tb_car_alarm_controller.sv
// -----------------------------------------------------------------------------
// tb_car_alarm_controller
// Directed scenarios followed by randomized inputs. A reference model keeps
// the alarm mode plus an absolute deadline (edge number) for the running
// phase, pushes the expected outputs for every edge into a queue, and a
// separate monitor pops and compares them on the falling edge.
// -----------------------------------------------------------------------------
module tb_car_alarm_controller;

    localparam int ARM_DELAY    = 6;
    localparam int ENTRY_DELAY  = 4;
    localparam int ALARM_CYCLES = 8;

    localparam int M_DISARMED = 0;
    localparam int M_ARMING   = 1;
    localparam int M_ARMED    = 2;
    localparam int M_ENTRY    = 3;
    localparam int M_ALARM    = 4;

    logic       clk;
    logic       reset;
    logic       IgnitionSignalOn;
    logic       OpenDoorSign;
    logic       CarLightsOnSign;
    logic       DisarmKey;
    logic       PassiveSignal_b;
    logic       PassiveSignal_s;
    logic       ArmedSign;
    logic [2:0] AlarmState;

    typedef struct {
        logic [2:0] st;
        logic       armed;
        logic       siren;
        logic       buzz;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   stim_done = 1'b0;

    car_alarm_controller #(
        .ARM_DELAY    (ARM_DELAY),
        .ENTRY_DELAY  (ENTRY_DELAY),
        .ALARM_CYCLES (ALARM_CYCLES),
        .CNT_W        (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .IgnitionSignalOn (IgnitionSignalOn),
        .OpenDoorSign     (OpenDoorSign),
        .CarLightsOnSign  (CarLightsOnSign),
        .DisarmKey        (DisarmKey),
        .PassiveSignal_b  (PassiveSignal_b),
        .PassiveSignal_s  (PassiveSignal_s),
        .ArmedSign        (ArmedSign),
        .AlarmState       (AlarmState)
    );

    // Clock generation, half-period 3.
    initial begin
        clk = 1'b0;
        forever #3 clk = ~clk;
    end

    // Reference model: mode plus absolute deadline, evaluated at every rising edge.
    initial begin
        int     mode;
        longint edge_n;
        longint deadline;
        exp_t   e;
        mode     = M_DISARMED;
        edge_n   = 0;
        deadline = 0;
        forever begin
            @(posedge clk);
            edge_n++;
            if (reset) begin
                mode = M_DISARMED;
            end else begin
                case (mode)
                    M_DISARMED: if (!IgnitionSignalOn && !OpenDoorSign) begin
                        mode = M_ARMING; deadline = edge_n + ARM_DELAY;
                    end
                    M_ARMING: begin
                        if (DisarmKey || IgnitionSignalOn || OpenDoorSign) mode = M_DISARMED;
                        else if (edge_n == deadline) mode = M_ARMED;
                    end
                    M_ARMED: begin
                        if (DisarmKey) mode = M_DISARMED;
                        else if (IgnitionSignalOn) begin
                            mode = M_ALARM; deadline = edge_n + ALARM_CYCLES;
                        end else if (OpenDoorSign) begin
                            mode = M_ENTRY; deadline = edge_n + ENTRY_DELAY;
                        end
                    end
                    M_ENTRY: begin
                        if (DisarmKey) mode = M_DISARMED;
                        else if (IgnitionSignalOn || edge_n == deadline) begin
                            mode = M_ALARM; deadline = edge_n + ALARM_CYCLES;
                        end
                    end
                    M_ALARM: begin
                        if (DisarmKey) mode = M_DISARMED;
                        else if (edge_n == deadline) mode = M_ARMED;
                    end
                    default: mode = M_DISARMED;
                endcase
            end
            e.st    = 3'(mode);
            e.armed = !reset && (mode == M_ARMED || mode == M_ENTRY || mode == M_ALARM);
            e.siren = !reset && (mode == M_ALARM);
            e.buzz  = !reset && ((mode == M_ENTRY) ||
                      ((mode == M_DISARMED || mode == M_ARMING) &&
                       !IgnitionSignalOn && CarLightsOnSign && OpenDoorSign));
            exp_q.push_back(e);
        end
    end

    // Monitor: pops one expectation per edge and compares on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (AlarmState !== e.st) begin
                    failures++;
                    $display("FAIL state t=%0t got=%0d exp=%0d", $time, AlarmState, e.st);
                end
                checks++;
                if (ArmedSign !== e.armed) begin
                    failures++;
                    $display("FAIL armed t=%0t got=%b exp=%b", $time, ArmedSign, e.armed);
                end
                checks++;
                if (PassiveSignal_s !== e.siren) begin
                    failures++;
                    $display("FAIL siren t=%0t got=%b exp=%b", $time, PassiveSignal_s, e.siren);
                end
                checks++;
                if (PassiveSignal_b !== e.buzz) begin
                    failures++;
                    $display("FAIL buzzer t=%0t got=%b exp=%b", $time, PassiveSignal_b, e.buzz);
                end
            end
        end
    end

    // Drive one input pattern for n cycles, changing only on the falling edge.
    task automatic drive(input logic r, input logic ign, input logic door,
                         input logic lights, input logic key, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            reset            = r;
            IgnitionSignalOn = ign;
            OpenDoorSign     = door;
            CarLightsOnSign  = lights;
            DisarmKey        = key;
        end
    endtask

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        reset            = 1'b1;
        IgnitionSignalOn = 1'b0;
        OpenDoorSign     = 1'b0;
        CarLightsOnSign  = 1'b0;
        DisarmKey        = 1'b0;
        // Reset, then arm.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8);
        // Door pulse while armed: entry, full siren, back to armed.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15);
        // Door, disarm at second entry cycle, then re-arm.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8);
        // Hotwire, then disarm on the expiry edge.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALARM_CYCLES - 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        // Lights-left-on chime, door close starts arming, ignition aborts.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2);
        // Re-arm, hotwire, reset mid-alarm.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2);
        // Randomized traffic weighted so that arming and alarms occur often.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset            = ($urandom_range(0, 199) == 0);
            IgnitionSignalOn = ($urandom_range(0, 24) == 0);
            OpenDoorSign     = ($urandom_range(0, 11) == 0);
            CarLightsOnSign  = 1'($urandom_range(0, 1));
            DisarmKey        = ($urandom_range(0, 39) == 0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        stim_done = 1'b1;
    end

    // Completion: bounded wait for stimulus, drain check, summary.
    initial begin
        int budget;
        budget = 0;
        while (!stim_done && budget < 20000) begin
            @(posedge clk);
            budget++;
        end
        checks++;
        if (!stim_done) begin
            failures++;
            $display("FAIL timeout got=%0d cycles exp=stimulus complete", budget);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() > 1) begin
            failures++;
            $display("FAIL drain got=%0d pending exp<=1", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
